// File: rtl/fifo_buffer_pkg.sv
// Shared sizing helpers for the FIFO and other small memory blocks.
package fifo_buffer_pkg;

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold any occupancy value from 0 to depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_buffer_ram.sv
// Simple dual-port register array: one write port, one registered read port.
module fifo_buffer_ram
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned WL    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WL-1:0]               wdata,
  input  logic                        re,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WL-1:0]               rdata
);

  logic [WL-1:0] mem_q [DEPTH];
  logic [WL-1:0] rdata_d;
  logic [WL-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data holds unless a read is performed.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with registered status flags and overflow/underflow error flag.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned WL    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          rReq,
  input  logic          wReq,
  input  logic [WL-1:0] din,
  output logic          Full,
  output logic          Empty,
  output logic          Error,
  output logic [WL-1:0] dout
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          full_d, full_q;
  logic          empty_d, empty_q;
  logic          error_d, error_q;
  logic          wr_ok_c;
  logic          rd_ok_c;

  // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
  always_comb begin
    wr_ok_c  = wReq & (~full_q | rReq);
    rd_ok_c  = rReq & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_ok_c) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_ok_c) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    if (wr_ok_c && !rd_ok_c) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok_c && !wr_ok_c) begin
      count_d = count_q - CW'(1);
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    error_d = (wReq & full_q & ~rReq) | (rReq & empty_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      error_q  <= error_d;
    end
  end

  fifo_buffer_ram #(
    .WL    (WL),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (CLK),
    .rst   (RST),
    .we    (wr_ok_c),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_ok_c),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign Full  = full_q;
  assign Empty = empty_q;
  assign Error = error_q;

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer (WL=8, DEPTH=8).
module tb_fifo_buffer;

  localparam int unsigned WL    = 8;
  localparam int unsigned DEPTH = 8;

  logic          CLK;
  logic          RST;
  logic          rReq;
  logic          wReq;
  logic [WL-1:0] din;
  logic          Full;
  logic          Empty;
  logic          Error;
  logic [WL-1:0] dout;

  int n_chk;
  int n_fail;

  fifo_buffer #(
    .WL    (WL),
    .DEPTH (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .rReq  (rReq),
    .wReq  (wReq),
    .din   (din),
    .Full  (Full),
    .Empty (Empty),
    .Error (Error),
    .dout  (dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests; returns at the following falling edge.
  task automatic cyc(input logic w, input logic r, input logic [WL-1:0] d);
    wReq = w;
    rReq = r;
    din  = d;
    @(negedge CLK);
    wReq = 1'b0;
    rReq = 1'b0;
  endtask

  task automatic flags(input string tag, input logic f, input logic e, input logic er);
    chk({tag, "_full"}, 32'(Full), 32'(f));
    chk({tag, "_empty"}, 32'(Empty), 32'(e));
    chk({tag, "_error"}, 32'(Error), 32'(er));
  endtask

  initial begin
    logic [7:0] seq_a [6];
    logic [7:0] seq_b [6];
    n_chk  = 0;
    n_fail = 0;
    seq_a  = '{8'd1, 8'd2, 8'd4, 8'd5, 8'd7, 8'd4};
    seq_b  = '{8'd2, 8'd4, 8'd5, 8'd7, 8'd4, 8'd3};
    RST  = 1'b1;
    wReq = 1'b0;
    rReq = 1'b0;
    din  = '0;
    repeat (2) @(negedge CLK);
    flags("reset", 1'b0, 1'b1, 1'b0);
    chk("reset_dout", 32'(dout), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Ordering
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, seq_a[i]);
    flags("six_wr", 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'd0);
    chk("first_rd", 32'(dout), 32'd1);
    cyc(1'b1, 1'b0, 8'd3);
    cyc(1'b1, 1'b0, 8'd1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk($sformatf("order_rd%0d", i), 32'(dout), 32'(seq_b[i]));
    end
    flags("one_left", 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'd0);
    chk("last_rd", 32'(dout), 32'd1);
    flags("drained", 1'b0, 1'b1, 1'b0);

    // Fill and overflow
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'(10 + i));
      chk($sformatf("fill%0d_full", i), 32'(Full), 32'(i == 7));
    end
    cyc(1'b1, 1'b0, 8'd99);
    flags("overflow", 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0);
    flags("ovf_idle", 1'b1, 1'b0, 1'b0);

    // Simultaneous read/write while full
    cyc(1'b1, 1'b1, 8'd55);
    flags("sim_full", 1'b1, 1'b0, 1'b0);
    chk("sim_full_dout", 32'(dout), 32'd10);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk($sformatf("drain%0d", i), 32'(dout), (i < 7) ? 32'(11 + i) : 32'd55);
    end
    flags("drain_done", 1'b0, 1'b1, 1'b0);

    // Underflow
    cyc(1'b0, 1'b1, 8'd0);
    flags("underflow", 1'b0, 1'b1, 1'b1);
    chk("uflow_dout", 32'(dout), 32'd55);
    cyc(1'b0, 1'b0, 8'd0);
    flags("uflow_idle", 1'b0, 1'b1, 1'b0);

    // Simultaneous read/write while empty: no bypass
    cyc(1'b1, 1'b1, 8'd66);
    flags("sim_empty", 1'b0, 1'b0, 1'b1);
    chk("sim_empty_dout", 32'(dout), 32'd55);
    cyc(1'b0, 1'b1, 8'd0);
    chk("sim_empty_rd", 32'(dout), 32'd66);
    flags("sim_empty_rd", 1'b0, 1'b1, 1'b0);

    // Wrap-around with interleaved write/read
    for (int n = 0; n < 20; n++) begin
      cyc(1'b1, 1'b0, 8'(100 + n));
      chk($sformatf("wrap%0d_empty", n), 32'(Empty), 32'd0);
      cyc(1'b0, 1'b1, 8'd0);
      chk($sformatf("wrap%0d_dout", n), 32'(dout), 32'(100 + n));
      chk($sformatf("wrap%0d_flags", n), 32'({Full, Empty, Error}), 32'b010);
    end

    // Asynchronous reset mid-operation
    cyc(1'b1, 1'b0, 8'd21);
    cyc(1'b1, 1'b0, 8'd22);
    cyc(1'b0, 1'b1, 8'd0);
    cyc(1'b0, 1'b1, 8'd0);
    cyc(1'b0, 1'b1, 8'd0);
    flags("pre_rst", 1'b0, 1'b1, 1'b1);
    chk("pre_rst_dout", 32'(dout), 32'd22);
    #2 RST = 1'b1;
    #1;
    flags("async_rst", 1'b0, 1'b1, 1'b0);
    chk("async_rst_dout", 32'(dout), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    cyc(1'b0, 1'b1, 8'd0);
    flags("post_rst_rd", 1'b0, 1'b1, 1'b1);
    chk("post_rst_dout", 32'(dout), 32'd0);
    cyc(1'b1, 1'b0, 8'd77);
    cyc(1'b0, 1'b1, 8'd0);
    chk("post_rst_data", 32'(dout), 32'd77);
    flags("post_rst_end", 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
